// File: rtl/pipe5_wb.sv
// Writeback stage: latches the memory-stage bundle, drives the regfile write port, owns HI/LO
// and turns a committed exception vector into a one-cycle flush. Optional trace: PIPE5_DEBUG_TRACE_EN.
module pipe5_wb #(
    parameter int          EX_W     = 6,
    parameter logic [31:0] HILO_RST = 32'h0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid,
    output logic            allow_in,
    input  logic [EX_W-1:0] ex,
    input  logic [31:0]     pc,
    input  logic [4:0]      dest,
    input  logic [31:0]     ctrl_info,
    input  logic [31:0]     ctrl_info2,
    input  logic [31:0]     wb_value,
    input  logic [31:0]     div_quotient,
    input  logic [31:0]     div_remainder,
    input  logic            div_complete,
    input  logic [31:0]     cp0_rdata,
    output logic [4:0]      cp0_raddr,
    output logic [EX_W-1:0] pipe5_ex,
    output logic            flush,
    output logic [31:0]     flush_pc,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [31:0]     rf_wdata,
    output logic            wb_valid,
    output logic [4:0]      wb_dest
`ifdef PIPE5_DEBUG_TRACE_EN
    ,
    output logic [31:0]     debug_wb_pc,
    output logic [3:0]      debug_wb_rf_wen,
    output logic [4:0]      debug_wb_rf_wnum,
    output logic [31:0]     debug_wb_rf_wdata,
    output logic [31:0]     retire_cnt
`endif
);

    logic            r_valid_p1;
    logic [EX_W-1:0] r_ex_p1;
    logic [31:0]     r_pc_p1;
    logic [4:0]      r_dest_p1;
    logic            r_reg_we_p1;
    logic            r_mfc0_p1;
    logic            r_mflo_p1;
    logic            r_mfhi_p1;
    logic            r_mtlo_p1;
    logic            r_mthi_p1;
    logic            r_div_p1;
    logic [31:0]     r_wb_value_p1;
    logic [31:0]     r_quot_p1;
    logic [31:0]     r_rem_p1;
    logic            r_div_done_p1;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    logic            w_exc;
    logic            w_commit;
    logic            w_unused_ctrl;

    assign w_unused_ctrl = &{1'b0, ctrl_info[31:28], ctrl_info[26:0],
                             ctrl_info2[31:15], ctrl_info2[9], ctrl_info2[7:0]};

    // Memory -> writeback boundary; a bundle arriving during a flush is dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid_p1    <= 1'b0;
            r_ex_p1       <= '0;
            r_pc_p1       <= '0;
            r_dest_p1     <= '0;
            r_reg_we_p1   <= 1'b0;
            r_mfc0_p1     <= 1'b0;
            r_mflo_p1     <= 1'b0;
            r_mfhi_p1     <= 1'b0;
            r_mtlo_p1     <= 1'b0;
            r_mthi_p1     <= 1'b0;
            r_div_p1      <= 1'b0;
            r_wb_value_p1 <= '0;
            r_quot_p1     <= '0;
            r_rem_p1      <= '0;
            r_div_done_p1 <= 1'b0;
        end else begin
            r_valid_p1 <= valid & ~w_exc;
            if (valid) begin
                r_ex_p1       <= ex;
                r_pc_p1       <= pc;
                r_dest_p1     <= dest;
                r_reg_we_p1   <= ctrl_info[27];
                r_mfc0_p1     <= ctrl_info2[8];
                r_mflo_p1     <= ctrl_info2[10];
                r_mfhi_p1     <= ctrl_info2[11];
                r_mtlo_p1     <= ctrl_info2[12];
                r_mthi_p1     <= ctrl_info2[13];
                r_div_p1      <= ctrl_info2[14];
                r_wb_value_p1 <= wb_value;
                r_quot_p1     <= div_quotient;
                r_rem_p1      <= div_remainder;
                r_div_done_p1 <= div_complete;
            end
        end
    end

    assign w_exc    = r_valid_p1 & (|r_ex_p1);
    assign w_commit = r_valid_p1 & ~w_exc;

    // Architectural HI/LO; a DIV without a finished result leaves both untouched
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= HILO_RST;
            r_lo <= HILO_RST;
        end else if (w_commit) begin
            if (r_div_p1) begin
                if (r_div_done_p1) begin
                    r_lo <= r_quot_p1;
                    r_hi <= r_rem_p1;
                end
            end else if (r_mthi_p1) begin
                r_hi <= r_wb_value_p1;
            end else if (r_mtlo_p1) begin
                r_lo <= r_wb_value_p1;
            end
        end
    end

    always_comb begin
        rf_wdata = r_wb_value_p1;
        if (r_mfhi_p1)
            rf_wdata = r_hi;
        else if (r_mflo_p1)
            rf_wdata = r_lo;
        else if (r_mfc0_p1)
            rf_wdata = cp0_rdata;
    end

    assign allow_in  = 1'b1;
    assign cp0_raddr = r_dest_p1;
    assign pipe5_ex  = r_valid_p1 ? r_ex_p1 : '0;
    assign flush     = w_exc;
    assign flush_pc  = r_pc_p1;
    assign rf_we     = w_commit & r_reg_we_p1 & (r_dest_p1 != 5'd0);
    assign rf_waddr  = r_dest_p1;
    assign wb_valid  = r_valid_p1;
    assign wb_dest   = (r_valid_p1 & r_reg_we_p1 & ~w_exc) ? r_dest_p1 : 5'd0;

`ifdef PIPE5_DEBUG_TRACE_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_retire_cnt <= '0;
        else if (w_commit)
            r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign retire_cnt        = r_retire_cnt;
    assign debug_wb_pc       = r_pc_p1;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_pipe5_wb.sv
// Scoreboarded bench for pipe5_wb: directed writeback/HI-LO/exception/reset cases plus random traffic
// against a transaction-level model of the writeback rules.
module tb_pipe5_wb;

    localparam int          EX_W = 6;
    localparam logic [31:0] HRST = 32'h0BADF00D;
    localparam logic [26:0] CP0_TAG = 27'h2ABCDEF;

    localparam int OP_NONE = 0;
    localparam int OP_MFC0 = 1;
    localparam int OP_MFLO = 2;
    localparam int OP_MFHI = 3;
    localparam int OP_MTLO = 4;
    localparam int OP_MTHI = 5;
    localparam int OP_DIV  = 6;

    logic            clk;
    logic            resetn;
    logic            valid;
    logic            allow_in;
    logic [EX_W-1:0] ex;
    logic [31:0]     pc;
    logic [4:0]      dest;
    logic [31:0]     ctrl_info;
    logic [31:0]     ctrl_info2;
    logic [31:0]     wb_value;
    logic [31:0]     div_quotient;
    logic [31:0]     div_remainder;
    logic            div_complete;
    logic [31:0]     cp0_rdata;
    logic [4:0]      cp0_raddr;
    logic [EX_W-1:0] pipe5_ex;
    logic            flush;
    logic [31:0]     flush_pc;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [31:0]     rf_wdata;
    logic            wb_valid;
    logic [4:0]      wb_dest;

    pipe5_wb #(.EX_W(EX_W), .HILO_RST(HRST)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .allow_in(allow_in),
        .ex(ex), .pc(pc), .dest(dest), .ctrl_info(ctrl_info), .ctrl_info2(ctrl_info2),
        .wb_value(wb_value), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_complete(div_complete), .cp0_rdata(cp0_rdata), .cp0_raddr(cp0_raddr),
        .pipe5_ex(pipe5_ex), .flush(flush), .flush_pc(flush_pc), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_valid(wb_valid), .wb_dest(wb_dest)
    );

    // CP0 stand-in: combinational read, data identifies the address
    assign cp0_rdata = {cp0_raddr, CP0_TAG};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        logic            wbv;
        logic            fl;
        logic [31:0]     fpc;
        logic [EX_W-1:0] exv;
        logic            we;
        logic [4:0]      wa;
        logic [31:0]     wd;
        logic [4:0]      wbd;
        logic [4:0]      ra;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state
    logic [31:0] m_hi, m_lo;
    logic        m_flush_pending;
    logic [4:0]  m_last_dest;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = HRST;
        m_lo = HRST;
        m_flush_pending = 1'b0;
        m_last_dest = 5'd0;
    endtask

    // Drive one bundle for one cycle and predict what the stage shows the cycle after capture
    task automatic issue(input logic v, input logic [EX_W-1:0] e, input logic [31:0] p,
                         input logic [4:0] d, input logic we, input int op,
                         input logic [31:0] val, input logic [31:0] q, input logic [31:0] r,
                         input logic dc);
        exp_t        x;
        logic        acc, exc, com;
        logic [31:0] ci, c2;
        ci = $urandom;
        ci[27] = we;
        c2 = $urandom & ~32'h0000_7D00;
        case (op)
            OP_MFC0: c2[8]  = 1'b1;
            OP_MFLO: c2[10] = 1'b1;
            OP_MFHI: c2[11] = 1'b1;
            OP_MTLO: c2[12] = 1'b1;
            OP_MTHI: c2[13] = 1'b1;
            OP_DIV:  c2[14] = 1'b1;
            default: ;
        endcase
        valid = v; ex = e; pc = p; dest = d; ctrl_info = ci; ctrl_info2 = c2;
        wb_value = val; div_quotient = q; div_remainder = r; div_complete = dc;

        acc = v & ~m_flush_pending;
        exc = acc & (e != '0);
        com = acc & ~exc;
        if (v) m_last_dest = d;
        x.cyc = cyc + 1;
        x.wbv = acc;
        x.fl  = exc;
        x.fpc = p;
        x.exv = acc ? e : '0;
        x.we  = com & we & (d != 5'd0);
        x.wa  = d;
        case (op)
            OP_MFHI: x.wd = m_hi;
            OP_MFLO: x.wd = m_lo;
            OP_MFC0: x.wd = {d, CP0_TAG};
            default: x.wd = val;
        endcase
        x.wbd = (acc & we & ~exc) ? d : 5'd0;
        x.ra  = m_last_dest;
        sb.push_back(x);
        if (com) begin
            if (op == OP_DIV) begin
                if (dc) begin m_lo = q; m_hi = r; end
            end else if (op == OP_MTHI) m_hi = val;
            else if (op == OP_MTLO) m_lo = val;
        end
        m_flush_pending = exc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue(1'b0, EX_W'($urandom), $urandom, 5'($urandom), 1'b1, $urandom_range(0, 6),
              $urandom, $urandom, $urandom, 1'b1);
    endtask

    // Monitor: pops the expectation due this cycle and compares away from the clock edge
    always @(negedge clk) begin
        if (resetn && sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("status{allow,wbv,flush,ex,we,wbdest}",
                64'({allow_in, wb_valid, flush, pipe5_ex, rf_we, wb_dest}),
                64'({1'b1, e.wbv, e.fl, e.exv, e.we, e.wbd}));
            chk("cp0_raddr", 64'(cp0_raddr), 64'(e.ra));
            if (e.we) chk("rf_write{waddr,wdata}", 64'({rf_waddr, rf_wdata}), 64'({e.wa, e.wd}));
            if (e.fl) chk("flush_pc", 64'(flush_pc), 64'(e.fpc));
        end
    end

    initial begin
        resetn = 1'b0;
        valid = 1'b0; ex = '0; pc = '0; dest = '0; ctrl_info = '0; ctrl_info2 = '0;
        wb_value = '0; div_quotient = '0; div_remainder = '0; div_complete = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({allow_in, wb_valid, flush, pipe5_ex, rf_we, wb_dest, cp0_raddr}),
            64'({1'b1, 1'b0, 1'b0, 6'h0, 1'b0, 5'd0, 5'd0}));
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // ALU write, dest=0 suppression, MTHI/MFHI/MFLO from reset
        issue(1, 0, 32'h0000_1000, 5'd5, 1, OP_NONE, 32'h0000_1234, 0, 0, 0);
        issue(1, 0, 32'h0000_1004, 5'd0, 1, OP_NONE, 32'hDEAD_BEEF, 0, 0, 0);
        issue(1, 0, 32'h0000_1008, 5'd0, 0, OP_MTHI, 32'hAAAA_5555, 0, 0, 0);
        issue(1, 0, 32'h0000_100C, 5'd1, 1, OP_MFHI, 32'h1111_1111, 0, 0, 0);
        issue(1, 0, 32'h0000_1010, 5'd2, 1, OP_MFLO, 32'h2222_2222, 0, 0, 0);
        // DIV then back-to-back MFHI/MFLO; incomplete DIV leaves HI/LO alone
        issue(1, 0, 32'h0000_1014, 5'd0, 0, OP_DIV, 0, 32'd7, 32'd3, 1);
        issue(1, 0, 32'h0000_1018, 5'd8, 1, OP_MFHI, 0, 0, 0, 0);
        issue(1, 0, 32'h0000_101C, 5'd9, 1, OP_MFLO, 0, 0, 0, 0);
        issue(1, 0, 32'h0000_1020, 5'd0, 0, OP_DIV, 0, 32'd99, 32'd98, 0);
        issue(1, 0, 32'h0000_1024, 5'd10, 1, OP_MFHI, 0, 0, 0, 0);
        issue(1, 0, 32'h0000_1028, 5'd12, 1, OP_MFC0, 32'h5555_0000, 0, 0, 0);
        issue(1, 0, 32'h0000_102C, 5'd0, 0, OP_MTLO, 32'h0F0F_F0F0, 0, 0, 0);
        issue(1, 0, 32'h0000_1030, 5'd13, 1, OP_MFLO, 0, 0, 0, 0);
        idle();
        // Exception: one-cycle flush, bundle in the flush cycle dropped, next one commits
        issue(1, 6'h04, 32'hBFC0_0100, 5'd7, 1, OP_MTHI, 32'h7777_7777, 0, 0, 0);
        issue(1, 0, 32'h0000_2000, 5'd10, 1, OP_NONE, 32'h0000_00AA, 0, 0, 0);
        issue(1, 0, 32'h0000_2004, 5'd11, 1, OP_MFHI, 32'h0000_00BB, 0, 0, 0);
        idle();

        // Reset mid-op: HI=9 confirmed, then async reset while an MFHI is in the stage
        issue(1, 0, 32'h0000_3000, 5'd0, 0, OP_MTHI, 32'd9, 0, 0, 0);
        issue(1, 0, 32'h0000_3004, 5'd4, 1, OP_MFHI, 0, 0, 0, 0);
        issue(1, 0, 32'h0000_3008, 5'd6, 1, OP_MFHI, 0, 0, 0, 0);
        valid = 1'b0;
        #2;
        resetn = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("async_reset_outputs", 64'({allow_in, wb_valid, flush, pipe5_ex, rf_we, wb_dest}),
            64'({1'b1, 1'b0, 1'b0, 6'h0, 1'b0, 5'd0}));
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 0, 32'h0000_3010, 5'd4, 1, OP_MFHI, 0, 0, 0, 0);
        issue(1, 0, 32'h0000_3014, 5'd5, 1, OP_MFLO, 0, 0, 0, 0);

        // Random traffic with sparse exceptions and bubbles
        for (int i = 0; i < 400; i++) begin
            logic            v;
            logic [EX_W-1:0] e;
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 7) == 0) ? EX_W'($urandom_range(1, (1 << EX_W) - 1)) : '0;
            issue(v, e, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 6),
                  $urandom, $urandom, $urandom, 1'($urandom));
        end
        issue(0, 0, 0, 0, 0, OP_NONE, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe5_wb.md
Name: pipe5_wb

Overview:
- Writeback stage; sits directly downstream of the memory stage and is the last pipeline stage.
- Latches the memory-stage bundle into its own pipeline register and drives the single register-file write port.
- Owns the architectural HI/LO registers: updated by divide completion and by MTHI/MTLO, read by MFHI/MFLO.
- Turns an exception vector arriving at commit into a one-cycle flush and feeds the vector back upstream.

Parameters:
- EX_W, 6, exception vector width.
- HILO_RST, 32'h0, reset value of the HI and LO registers.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- valid  in  1  upstream bundle valid.
- allow_in  out  1  stage can accept a bundle this cycle.
- ex  in  EX_W  exception vector.
- pc  in  32  instruction PC.
- dest  in  5  destination GPR.
- ctrl_info  in  32  control word: bit 27 is reg_we.
- ctrl_info2  in  32  control word 2: bit 8 MFC0, 10 MFLO, 11 MFHI, 12 MTLO, 13 MTHI, 14 DIV.
- wb_value  in  32  load/ALU result.
- div_quotient  in  32  divider quotient.
- div_remainder  in  32  divider remainder.
- div_complete  in  1  divider result valid for this bundle.
- cp0_rdata  in  32  CP0 read data for MFC0; combinational from cp0_raddr.
- cp0_raddr  out  5  equals latched dest field (rd of MFC0).
- pipe5_ex  out  EX_W  latched ex when stage valid, else 0.
- flush  out  1  exception commit pulse.
- flush_pc  out  32  PC of the excepting instruction.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  32  write data.
- wb_valid  out  1  stage holds a valid bundle; for hazard logic.
- wb_dest  out  5  latched dest, or 0 if no GPR write; for hazard logic.

Behaviour:
- Reset (resetn low, async):
  - valid_r=0; all latched fields=0; HI=LO=HILO_RST.
  - Outputs: rf_we=0, flush=0, pipe5_ex=0, wb_valid=0, wb_dest=0, allow_in=1.
- allow_in = 1 always; writeback never stalls.
- Capture: at each posedge, valid_r <= valid & ~flush. Fields latch only when valid=1; otherwise they are held.
- Latency: bundle presented at edge N.
  - Regfile write is combinational during cycle N..N+1.
  - HI/LO update takes effect at edge N+1.
- Definitions:
  - exc = valid_r & (|ex_r).
  - commit = valid_r & ~exc.
- rf_we = commit & reg_we_r & (dest_r != 0); rf_waddr = dest_r.
- rf_wdata priority:
  1. MFHI: HI.
  2. MFLO: LO.
  3. MFC0: cp0_rdata.
  4. Otherwise: wb_value_r.
- rf_wdata on an MFHI/MFLO commit reflects HI/LO updated by any earlier committed instruction, including one committed the previous cycle.
- HI/LO update at edge, only when commit:
  - DIV & div_complete_r: LO <= quotient, HI <= remainder.
  - Else MTHI: HI <= wb_value_r.
  - Else MTLO: LO <= wb_value_r.
  - DIV without div_complete_r: no update.
- Exception handling:
  - flush = exc and flush_pc = pc_r, for exactly the cycle exc holds.
  - No regfile write and no HI/LO write when exc=1.
  - Bundle arriving with valid=1 in a flush cycle is discarded: valid_r goes 0 next cycle.
- pipe5_ex = valid_r ? ex_r : 0.
- wb_valid = valid_r; wb_dest = (valid_r & reg_we_r & ~exc) ? dest_r : 0.
- Back-to-back valid bundles commit one per cycle with no bubbles.
- Reset mid-stream: all in-flight state is dropped, HI/LO return to HILO_RST, and no write occurs in the reset cycle.

Optional Feature:
- Macro: PIPE5_DEBUG_TRACE_EN.
- Defined: adds outputs
  - debug_wb_pc[31:0] = pc_r.
  - debug_wb_rf_wen[3:0] = {4{rf_we}}.
  - debug_wb_rf_wnum[4:0] = rf_waddr.
  - debug_wb_rf_wdata[31:0] = rf_wdata.
  - retire_cnt[31:0]: increments on each commit, wraps 32'hFFFFFFFF->0, reset 0.
- Undefined: these ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- ALU write: valid=1, reg_we=1, dest=5, wb_value=32'h1234, ex=0 -> next cycle rf_we=1, waddr=5, wdata=32'h1234.
- dest=0 write: dest=0, reg_we=1 -> rf_we=0 and wb_dest=0.
- DIV then MFHI/MFLO:
  - DIV with div_complete=1, quotient=7, remainder=3.
  - Then MFHI dest=8 next cycle -> rf_wdata=3.
  - Then MFLO dest=9 -> rf_wdata=7.
- MTHI/MTLO: MTHI wb_value=32'hAAAA5555, then MFHI -> rf_wdata=32'hAAAA5555; LO unchanged from HILO_RST.
- Exception:
  - Bundle ex=6'h04, pc=32'hBFC00100, reg_we=1 -> flush=1 for one cycle, flush_pc=32'hBFC00100, pipe5_ex=6'h04, rf_we=0.
  - Valid bundle presented that same cycle -> wb_valid=0 next cycle.
- Reset mid-op: after HI written to 9, assert resetn=0 asynchronously mid-cycle -> outputs zero immediately, HI=HILO_RST; after release, MFHI returns HILO_RST.
